// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and default oversampling.
// Used by uart_transmitter, uart_bit_timer and uart_receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: bit_end pulses for one cycle every OVERSAMPLE clk cycles.
// clear restarts the period so that a new frame's first bit gets a full OVERSAMPLE cycles.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int TICK_WIDTH = $clog2(OVERSAMPLE);
    localparam logic [TICK_WIDTH-1:0] LAST_TICK = TICK_WIDTH'(OVERSAMPLE - 1);

    logic [TICK_WIDTH-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tick_cnt <= '0;
        end else if (tick_cnt == LAST_TICK) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign bit_end = (tick_cnt == LAST_TICK);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_SIZE data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit (parity_odd selects odd/even).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_SIZE      = 8,
    parameter int OVERSAMPLE     = UART_OVERSAMPLE,
    parameter int STOP_BITS      = 1,
    parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start_n,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 parity_odd,
    output logic                 serial_data_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] ST_IDLE   = TX_IDLE;
    localparam logic [2:0] ST_START  = TX_START;
    localparam logic [2:0] ST_DATA   = TX_DATA;
    localparam logic [2:0] ST_STOP   = TX_STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = TX_PARITY;
`endif

    localparam logic [BIT_COUNT_SIZE-1:0] LAST_BIT = BIT_COUNT_SIZE'(DATA_SIZE - 1);
    localparam logic                      LAST_STOP = 1'(STOP_BITS - 1);

    logic [2:0]                state;
    logic [DATA_SIZE-1:0]      shift_reg;
    logic [BIT_COUNT_SIZE-1:0] bit_cnt;
    logic                      stop_cnt;
    logic                      accept;
    logic                      bit_end;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign accept = (state == ST_IDLE) && !tx_start_n;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .bit_end(bit_end)
    );

    // The timer is restarted on acceptance, so every state simply advances on bit_end.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            serial_data_out <= UART_IDLE_LEVEL;
            tx_busy         <= 1'b0;
            tx_done         <= 1'b0;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            stop_cnt        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit      <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!tx_start_n) begin
                        state           <= ST_START;
                        serial_data_out <= UART_START_LEVEL;
                        tx_busy         <= 1'b1;
                        shift_reg       <= data_in;
                        bit_cnt         <= '0;
                        stop_cnt        <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_bit      <= (^data_in) ^ parity_odd;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state           <= ST_DATA;
                        serial_data_out <= shift_reg[0];
                        shift_reg       <= shift_reg >> 1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state           <= ST_PARITY;
                            serial_data_out <= parity_bit;
`else
                            state           <= ST_STOP;
                            serial_data_out <= UART_IDLE_LEVEL;
                            stop_cnt        <= 1'b0;
`endif
                        end else begin
                            serial_data_out <= shift_reg[0];
                            shift_reg       <= shift_reg >> 1;
                            bit_cnt         <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state           <= ST_STOP;
                        serial_data_out <= UART_IDLE_LEVEL;
                        stop_cnt        <= 1'b0;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == LAST_STOP) begin
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    serial_data_out <= UART_IDLE_LEVEL;
                    tx_busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a frame-level line model checked every cycle,
// plus hand-computed frame waveforms, on a 1-stop-bit and a 2-stop-bit instance.
module tb_uart_transmitter;

    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam logic [15:0] LIT_A5_EVEN  = 16'b0000_0101_0100_1010;
    localparam logic [15:0] LIT_A5_ODD   = 16'b0000_0111_0100_1010;
    localparam logic [15:0] LIT_00_2STOP = 16'b0000_1100_0000_0000;
`else
    localparam int P = 0;
    localparam logic [15:0] LIT_A5_EVEN  = 16'b0000_0011_0100_1010;
    localparam logic [15:0] LIT_A5_ODD   = 16'b0000_0011_0100_1010;
    localparam logic [15:0] LIT_00_2STOP = 16'b0000_0110_0000_0000;
`endif
    localparam int NB_ONE = 1 + 8 + P + 1;
    localparam int NB_TWO = 1 + 8 + P + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] start_n = 2'b11;
    logic [1:0] odd = 2'b00;
    logic [7:0] data_a [2];
    logic [1:0] line, busy, done;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    uart_transmitter #(.DATA_SIZE(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .tx_start_n(start_n[0]), .data_in(data_a[0]),
        .parity_odd(odd[0]), .serial_data_out(line[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    uart_transmitter #(.DATA_SIZE(8), .OVERSAMPLE(OS), .STOP_BITS(2)) dut_two_stop (
        .clk(clk), .reset(reset), .tx_start_n(start_n[1]), .data_in(data_a[1]),
        .parity_odd(odd[1]), .serial_data_out(line[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    // Frame model: on acceptance build the whole line waveform as a bit list, then play it out.
    int          m_pos [2] = '{-1, -1};
    int          m_nb [2];
    logic [15:0] m_bits [2];
    logic [1:0]  e_line = 2'b11, e_busy = 2'b00, e_done = 2'b00;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_done[i] = 1'b0;
            if (reset) begin
                m_pos[i] = -1;
            end else if (m_pos[i] < 0) begin
                if (!start_n[i]) begin
                    m_nb[i]      = 1 + 8 + P + ((i == 0) ? 1 : 2);
                    m_bits[i]    = '1;
                    m_bits[i][0] = 1'b0;
                    for (int j = 0; j < 8; j++) m_bits[i][1 + j] = data_a[i][j];
                    if (P != 0) m_bits[i][9] = (^data_a[i]) ^ odd[i];
                    m_pos[i] = 0;
                end
            end else begin
                m_pos[i]++;
                if (m_pos[i] == m_nb[i] * OS) begin
                    e_done[i] = 1'b1;
                    m_pos[i]  = -1;
                end
            end
            if (m_pos[i] >= 0) begin
                e_line[i] = m_bits[i][m_pos[i] / OS];
                e_busy[i] = 1'b1;
            end else begin
                e_line[i] = 1'b1;
                e_busy[i] = 1'b0;
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                check_val($sformatf("model line[%0d]", i), 32'(line[i]), 32'(e_line[i]));
                check_val($sformatf("model busy[%0d]", i), 32'(busy[i]), 32'(e_busy[i]));
                check_val($sformatf("model done[%0d]", i), 32'(done[i]), 32'(e_done[i]));
            end
        end
    end

    task automatic wait_idle(input int idx);
        bit idle = 1'b0;
        for (int c = 0; c < 1000 && !idle; c++) begin
            @(negedge clk);
            if (!busy[idx]) idle = 1'b1;
        end
        check_val($sformatf("idle reached[%0d]", idx), 32'(idle), 32'd1);
    endtask

    task automatic wait_done(input int idx);
        bit seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (done[idx]) seen = 1'b1;
        end
        check_val($sformatf("done seen[%0d]", idx), 32'(seen), 32'd1);
    endtask

    // Sends one word and checks each bit mid-period against a hand-written waveform.
    task automatic applyStimulus(input int idx, input logic [7:0] d, input logic o,
                                 input logic [15:0] lit, input int nb);
        wait_idle(idx);
        @(posedge clk); #2;
        start_n[idx] = 1'b0; data_a[idx] = d; odd[idx] = o;
        @(posedge clk); #2;
        start_n[idx] = 1'b1; data_a[idx] = ~d; odd[idx] = ~o;
        for (int k = 0; k < nb; k++) begin
            repeat ((k == 0) ? 8 : 16) @(posedge clk);
            @(negedge clk);
            check_val($sformatf("lit bit %0d [%0d]", k, idx), 32'(line[idx]), 32'(lit[k]));
            check_val($sformatf("lit busy %0d [%0d]", k, idx), 32'(busy[idx]), 32'd1);
        end
        repeat (7) @(posedge clk);
        @(negedge clk);
        check_val("lit busy before end", 32'(busy[idx]), 32'd1);
        check_val("lit done before end", 32'(done[idx]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("lit done at end", 32'(done[idx]), 32'd1);
        check_val("lit busy at end", 32'(busy[idx]), 32'd0);
        check_val("lit line at end", 32'(line[idx]), 32'd1);
        @(negedge clk);
        check_val("lit done width", 32'(done[idx]), 32'd0);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int done_cnt;
        data_a[0] = 8'h00;
        data_a[1] = 8'h00;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        check_en = 1'b1;

        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check_val("idle line", 32'(line[0]), 32'd1);
            check_val("idle busy", 32'(busy[0]), 32'd0);
            check_val("idle done", 32'(done[0]), 32'd0);
        end

        applyStimulus(0, 8'hA5, 1'b0, LIT_A5_EVEN, NB_ONE);
        applyStimulus(0, 8'hA5, 1'b1, LIT_A5_ODD, NB_ONE);

        // Back-to-back with request held low and data switched mid-frame.
        wait_idle(0);
        @(posedge clk); #2;
        start_n[0] = 1'b0; data_a[0] = 8'h3C; odd[0] = 1'b0;
        repeat (51) @(posedge clk);
        #2 data_a[0] = 8'hC3;
        wait_done(0);
        check_val("b2b gap busy", 32'(busy[0]), 32'd0);
        check_val("b2b gap line", 32'(line[0]), 32'd1);
        @(negedge clk);
        check_val("b2b restart busy", 32'(busy[0]), 32'd1);
        check_val("b2b restart line", 32'(line[0]), 32'd0);
        @(posedge clk); #2 start_n[0] = 1'b1;
        wait_idle(0);

        // Reset in the middle of a frame.
        @(posedge clk); #2;
        start_n[0] = 1'b0; data_a[0] = 8'h5A;
        @(posedge clk); #2 start_n[0] = 1'b1;
        repeat (49) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check_val("abort line", 32'(line[0]), 32'd1);
        check_val("abort busy", 32'(busy[0]), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done[0]) done_cnt++;
        end
        check_val("abort no done", 32'(done_cnt), 32'd0);
        applyStimulus(0, 8'hA5, 1'b0, LIT_A5_EVEN, NB_ONE);

        applyStimulus(1, 8'h00, 1'b0, LIT_00_2STOP, NB_TWO);

        for (int r = 0; r < 14; r++) begin
            int idx;
            int hold;
            idx  = int'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 4));
            wait_idle(idx);
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #2;
            start_n[idx] = 1'b0;
            data_a[idx]  = 8'($urandom);
            odd[idx]     = 1'($urandom);
            repeat (hold) begin
                @(posedge clk); #2;
                data_a[idx] = 8'($urandom);
                odd[idx]    = 1'($urandom);
            end
            start_n[idx] = 1'b1;
        end

        wait_idle(0);
        wait_idle(1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Transmit half of the UART: serialises one DATA_SIZE-bit word per request into a frame on serial_data_out. Frame order is start bit, data LSB first, optional parity bit, then stop bit(s).
- Runs on the same 16x oversampling clock that drives uart_receiver. Each bit is held for OVERSAMPLE clk cycles, so its line output connects directly to the receiver's serial_data_in.

Parameters:
- DATA_SIZE, 8, data bits per frame (5..9 supported)
- OVERSAMPLE, 16, clk cycles per bit (>=2)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- BIT_COUNT_SIZE, $clog2(DATA_SIZE+1), width of the data-bit counter (derived; do not override)

Ports:
- clk  input  1  oversampling clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- tx_start_n  input  1  active-low transmit request; sampled only in IDLE
- data_in  input  DATA_SIZE  word to send; captured on the accepting edge
- parity_odd  input  1  1 = odd parity, 0 = even parity; sampled on the accepting edge
- serial_data_out  output  1  UART line; idles high
- tx_busy  output  1  high while a frame is in flight
- tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset: while reset is high at a clk edge, the block goes to:
  - state IDLE
  - serial_data_out=1, tx_busy=0, tx_done=0
  - counters=0, shift register=0
- Reset mid-frame aborts the frame immediately; the line returns high on the next cycle and no tx_done pulse is produced.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. All outputs are registered.
- Acceptance: in IDLE, tx_start_n sampled low at edge T triggers acceptance:
  - data_in and parity_odd are latched
  - state becomes START, serial_data_out=0, tx_busy=1, all from edge T onward
- tx_start_n is ignored outside IDLE. No queuing; a request held low through the frame is accepted on the first IDLE cycle.
- Bit timing: tick_cnt counts 0..OVERSAMPLE-1 and wraps; a bit ends on the edge where tick_cnt==OVERSAMPLE-1.
- START ends -> DATA:
  - bit 0 is driven
  - bit_cnt counts DATA_SIZE bits, shifting right, LSB first
- After the last data bit -> PARITY if enabled, else STOP. serial_data_out=1 for STOP_BITS*OVERSAMPLE cycles.
- Last stop tick at edge T+N*OVERSAMPLE, where N = 1+DATA_SIZE+P+STOP_BITS and P = 1 with parity, 0 without. At that edge:
  - state becomes IDLE, tx_busy=0, tx_done=1 for exactly one cycle
- Back-to-back: tx_start_n low during the tx_done cycle is accepted at the next edge. The stop level therefore lasts at least STOP_BITS*OVERSAMPLE+1 cycles; this is legal.
- data_in changing after acceptance has no effect on the frame in flight.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - the PARITY state is present
  - the parity bit is ^data_latched when even, ~^data_latched when odd
  - it is held for OVERSAMPLE cycles between the last data bit and the stop bit(s)
- Undefined:
  - no PARITY state; P=0
  - parity_odd is unused and stays in the port list so connections are stable

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [2:0] tx_state_e {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP}
  - constants UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0
  - default OVERSAMPLE, reused by uart_receiver
- One sub-module, uart_bit_timer:
  - parameter OVERSAMPLE
  - inputs clk, reset, clear
  - output bit_end, a single-cycle pulse every OVERSAMPLE cycles
  - the FSM asserts clear on acceptance

Test Plan:
- Reset, then hold tx_start_n=1 for 100 cycles -> serial_data_out=1, tx_busy=0, tx_done=0 throughout.
- Macro off, data_in=8'hA5, 1-cycle tx_start_n pulse at edge T:
  - line carries 0,1,0,1,0,0,1,0,1 then stop 1, each 16 cycles
  - tx_busy=1 over [T, T+160)
  - tx_done pulse at T+160
- Macro on, 8'hA5:
  - parity_odd=0 -> parity bit 0
  - repeat with parity_odd=1 -> parity bit 1
  - tx_done at T+176
- tx_start_n held low, data 8'h3C then 8'hC3 switched mid-frame:
  - first frame carries 8'h3C
  - second frame starts one cycle after the tx_done pulse and carries 8'hC3
- Assert reset for 1 cycle at T+50 of a frame -> line high next cycle, tx_busy=0, no tx_done; a new request then transmits correctly.
- STOP_BITS=2, data 8'h00 -> stop high for 32 cycles; tx_done at T+176.
